// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the shift operand stage: datapath width, shift-type
// encodings seen by the downstream shifter, the funct3 values that select a
// shift, and the decode helper that turns instruction fields into a type.
// ---------------------------------------------------------------------------
package shift_pkg;

  localparam int XLEN = 32;

  // Shift operation handed to the shifter stage
  typedef enum logic [1:0] {
    SHIFT_SRL  = 2'b00,
    SHIFT_SLL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_PASS = 2'b11
  } shift_type_e;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SR  = 3'b101;

  // funct7 bit 5 separates arithmetic from logical right shifts; any funct3
  // that is not a shift lets the operand pass through unmodified.
  function automatic shift_type_e decode_shift_type(input logic [2:0] funct3,
                                                    input logic       funct7b5);
    shift_type_e t;
    case (funct3)
      FUNCT3_SLL: t = SHIFT_SLL;
      FUNCT3_SR:  t = funct7b5 ? SHIFT_SRA : SHIFT_SRL;
      default:    t = SHIFT_PASS;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/shift_operand_stage_if.sv
// ---------------------------------------------------------------------------
// shift_operand_stage_if
// Handshake bundle around the shift operand stage.
//   Decode side : in_valid/in_ready plus register values, indices, immediate
//                 and the decode fields (funct3, funct7b5, use_imm).
//   Shifter side: out_valid/out_ready plus the registered operands
//                 out_a, out_shamt, out_type and out_rd.
// Modports:
//   master - the environment (drives decode fields and out_ready)
//   slave  - the stage itself
// ---------------------------------------------------------------------------
interface shift_operand_stage_if;
  import shift_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_rs1_val;
  logic [XLEN-1:0] in_rs2_val;
  logic [4:0]      in_rs1_idx;
  logic [4:0]      in_rs2_idx;
  logic [4:0]      in_rd_idx;
  logic [XLEN-1:0] in_imm;
  logic [2:0]      in_funct3;
  logic            in_funct7b5;
  logic            in_use_imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_a;
  logic [4:0]      out_shamt;
  logic [1:0]      out_type;
  logic [4:0]      out_rd;

  modport master (
    output in_valid, in_rs1_val, in_rs2_val, in_rs1_idx, in_rs2_idx, in_rd_idx,
           in_imm, in_funct3, in_funct7b5, in_use_imm, out_ready,
    input  in_ready, out_valid, out_a, out_shamt, out_type, out_rd
  );

  modport slave (
    input  in_valid, in_rs1_val, in_rs2_val, in_rs1_idx, in_rs2_idx, in_rd_idx,
           in_imm, in_funct3, in_funct7b5, in_use_imm, out_ready,
    output in_ready, out_valid, out_a, out_shamt, out_type, out_rd
  );

endinterface

// File: rtl/shift_fwd_mux.sv
// ---------------------------------------------------------------------------
// shift_fwd_mux
// Priority source select for one source operand (purely combinational).
// Ports:
//   idx                 - architectural register index of the operand
//   rf_val              - register-file read value
//   exm_valid/rd/data   - EX/MEM forwarding source (highest priority)
//   mwb_valid/rd/data   - MEM/WB forwarding source
//   val                 - resolved operand
// x0 is hardwired to zero, so a producer that names rd=0 can never leak a
// value into an operand.
// ---------------------------------------------------------------------------
module shift_fwd_mux
  import shift_pkg::*;
#(
  parameter int W = XLEN
) (
  input  logic [4:0]   idx,
  input  logic [W-1:0] rf_val,
  input  logic         exm_valid,
  input  logic [4:0]   exm_rd,
  input  logic [W-1:0] exm_data,
  input  logic         mwb_valid,
  input  logic [4:0]   mwb_rd,
  input  logic [W-1:0] mwb_data,
  output logic [W-1:0] val
);

  logic exm_hit;
  logic mwb_hit;

  assign exm_hit = exm_valid && (exm_rd == idx);
  assign mwb_hit = mwb_valid && (mwb_rd == idx);

  // The younger EX/MEM result shadows the older MEM/WB one
  always_comb begin
    val = rf_val;
    if (idx == 5'd0) begin
      val = '0;
    end else if (exm_hit) begin
      val = exm_data;
    end else if (mwb_hit) begin
      val = mwb_data;
    end
  end

endmodule

// File: rtl/shift_operand_stage.sv
// ---------------------------------------------------------------------------
// shift_operand_stage
// One-entry pipeline register that resolves shift operands and decodes the
// shift type for the shifter stage. Latency is one cycle; the output set is
// held while the shifter back-pressures.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   bus (slave)         - decode handshake in, shifter handshake out
//   flush               - kills the held set and any same-cycle input
//   exm_fwd_*, mwb_fwd_*- forwarding sources (EX/MEM wins over MEM/WB)
//   stall_cnt           - saturating count of back-pressured cycles
// Configuration:
//   SHIFT_OPERAND_FWD_EN - when defined, operands are forwarded from the
//                          EX/MEM and MEM/WB sources; otherwise the fwd ports
//                          are present but ignored.
// ---------------------------------------------------------------------------
module shift_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_operand_stage_if.slave bus,
  input  logic              flush,
  input  logic              exm_fwd_valid,
  input  logic [4:0]        exm_fwd_rd,
  input  logic [XLEN-1:0]   exm_fwd_data,
  input  logic              mwb_fwd_valid,
  input  logic [4:0]        mwb_fwd_rd,
  input  logic [XLEN-1:0]   mwb_fwd_data,
  output logic [15:0]       stall_cnt
);

  import shift_pkg::*;

  logic            out_valid_q;
  logic [XLEN-1:0] out_a_q;
  logic [4:0]      out_shamt_q;
  shift_type_e     out_type_q;
  logic [4:0]      out_rd_q;
  logic [15:0]     stall_q;

  logic            in_ready;
  logic            accept;
  logic [XLEN-1:0] rs1_res;
  logic [XLEN-1:0] rs2_res;
  logic            fwd_exm_valid;
  logic            fwd_mwb_valid;
  logic            unused_bits;

  // The forwarding sources are gated here so the mux instances stay
  // identical in both builds.
`ifdef SHIFT_OPERAND_FWD_EN
  assign fwd_exm_valid = exm_fwd_valid;
  assign fwd_mwb_valid = mwb_fwd_valid;
  assign unused_bits   = ^{bus.in_imm[XLEN-1:5], rs2_res[XLEN-1:5]};
`else
  assign fwd_exm_valid = 1'b0;
  assign fwd_mwb_valid = 1'b0;
  assign unused_bits   = ^{bus.in_imm[XLEN-1:5], rs2_res[XLEN-1:5],
                           exm_fwd_valid, mwb_fwd_valid};
`endif

  shift_fwd_mux #(.W(XLEN)) u_rs1_mux (
    .idx       (bus.in_rs1_idx),
    .rf_val    (bus.in_rs1_val),
    .exm_valid (fwd_exm_valid),
    .exm_rd    (exm_fwd_rd),
    .exm_data  (exm_fwd_data),
    .mwb_valid (fwd_mwb_valid),
    .mwb_rd    (mwb_fwd_rd),
    .mwb_data  (mwb_fwd_data),
    .val       (rs1_res)
  );

  shift_fwd_mux #(.W(XLEN)) u_rs2_mux (
    .idx       (bus.in_rs2_idx),
    .rf_val    (bus.in_rs2_val),
    .exm_valid (fwd_exm_valid),
    .exm_rd    (exm_fwd_rd),
    .exm_data  (exm_fwd_data),
    .mwb_valid (fwd_mwb_valid),
    .mwb_rd    (mwb_fwd_rd),
    .mwb_data  (mwb_fwd_data),
    .val       (rs2_res)
  );

  // The single slot can take a new set when empty or when its current
  // contents leave this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Operand register: flush wins over both loading and holding; the data
  // fields are only written on accept so they stay stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_shamt_q <= '0;
      out_type_q  <= SHIFT_PASS;
      out_rd_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_a_q     <= rs1_res;
      out_shamt_q <= bus.in_use_imm ? bus.in_imm[4:0] : rs2_res[4:0];
      out_type_q  <= decode_shift_type(bus.in_funct3, bus.in_funct7b5);
      out_rd_q    <= bus.in_rd_idx;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Back-pressure counter sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !bus.out_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_shamt = out_shamt_q;
  assign bus.out_type  = out_type_q;
  assign bus.out_rd    = out_rd_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_shift_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_shift_operand_stage
// Directed bench for shift_operand_stage. Expected operand sets are computed
// from the instruction fields when driven, queued, and popped when the stage
// presents its output. Forwarding expectations follow SHIFT_OPERAND_FWD_EN.
// ---------------------------------------------------------------------------
module tb_shift_operand_stage;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  typ;
    logic [4:0]  rd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        exm_v;
  logic [4:0]  exm_rd;
  logic [31:0] exm_d;
  logic        mwb_v;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_d;
  logic [15:0] stall_cnt;

  int   compared;
  int   mismatched;
  exp_t sb[$];
  exp_t last;

  shift_operand_stage_if sif ();

  shift_operand_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (sif.slave),
    .flush         (flush),
    .exm_fwd_valid (exm_v),
    .exm_fwd_rd    (exm_rd),
    .exm_fwd_data  (exm_d),
    .mwb_fwd_valid (mwb_v),
    .mwb_fwd_rd    (mwb_rd),
    .mwb_fwd_data  (mwb_d),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand source model: register value unless a forwarding source applies
  function automatic logic [31:0] model_operand(input logic [4:0] idx, input logic [31:0] rf);
`ifdef SHIFT_OPERAND_FWD_EN
    if (idx == 5'd0) return 32'd0;
    if (exm_v && exm_rd == idx) return exm_d;
    if (mwb_v && mwb_rd == idx) return mwb_d;
`endif
    return rf;
  endfunction

  function automatic logic [1:0] model_type(input logic [2:0] f3, input logic f7b5);
    if (f3 == 3'b001) return 2'b01;
    if (f3 == 3'b101) return f7b5 ? 2'b10 : 2'b00;
    return 2'b11;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one decoded instruction; queue its expected result if it will be taken
  task automatic applyStimulus(input logic [4:0] rs1i, input logic [31:0] rs1v,
                               input logic [4:0] rs2i, input logic [31:0] rs2v,
                               input logic [4:0] rdi, input logic [31:0] imm,
                               input logic [2:0] f3, input logic f7b5, input logic ui,
                               input bit will_accept);
    exp_t e;
    logic [31:0] r2;
    sif.in_valid    = 1'b1;
    sif.in_rs1_idx  = rs1i;
    sif.in_rs1_val  = rs1v;
    sif.in_rs2_idx  = rs2i;
    sif.in_rs2_val  = rs2v;
    sif.in_rd_idx   = rdi;
    sif.in_imm      = imm;
    sif.in_funct3   = f3;
    sif.in_funct7b5 = f7b5;
    sif.in_use_imm  = ui;
    r2      = model_operand(rs2i, rs2v);
    e.a     = model_operand(rs1i, rs1v);
    e.shamt = ui ? imm[4:0] : r2[4:0];
    e.typ   = model_type(f3, f7b5);
    e.rd    = rdi;
    if (will_accept) sb.push_back(e);
  endtask

  task automatic idle_input();
    sif.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    check_val({tag, "_valid"}, {31'd0, sif.out_valid}, 32'd1);
    check_val({tag, "_queued"}, {31'd0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      last = sb.pop_front();
      check_val({tag, "_a"}, sif.out_a, last.a);
      check_val({tag, "_shamt"}, {27'd0, sif.out_shamt}, {27'd0, last.shamt});
      check_val({tag, "_type"}, {30'd0, sif.out_type}, {30'd0, last.typ});
      check_val({tag, "_rd"}, {27'd0, sif.out_rd}, {27'd0, last.rd});
    end
  endtask

  task automatic check_held(input string tag);
    check_val({tag, "_valid"}, {31'd0, sif.out_valid}, 32'd1);
    check_val({tag, "_ready"}, {31'd0, sif.in_ready}, 32'd0);
    check_val({tag, "_a"}, sif.out_a, last.a);
    check_val({tag, "_shamt"}, {27'd0, sif.out_shamt}, {27'd0, last.shamt});
    check_val({tag, "_type"}, {30'd0, sif.out_type}, {30'd0, last.typ});
    check_val({tag, "_rd"}, {27'd0, sif.out_rd}, {27'd0, last.rd});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b1;
    flush = 1'b0;
    exm_v = 1'b0; exm_rd = '0; exm_d = '0;
    mwb_v = 1'b0; mwb_rd = '0; mwb_d = '0;
    sif.out_ready = 1'b1;
    sif.in_valid = 1'b0;
    sif.in_rs1_idx = '0; sif.in_rs1_val = '0;
    sif.in_rs2_idx = '0; sif.in_rs2_val = '0;
    sif.in_rd_idx = '0;  sif.in_imm = '0;
    sif.in_funct3 = '0;  sif.in_funct7b5 = 1'b0; sif.in_use_imm = 1'b0;
    #2 rst_n = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_val("rst_valid", {31'd0, sif.out_valid}, 32'd0);
    check_val("rst_a", sif.out_a, 32'd0);
    check_val("rst_shamt", {27'd0, sif.out_shamt}, 32'd0);
    check_val("rst_type", {30'd0, sif.out_type}, 32'd3);
    check_val("rst_rd", {27'd0, sif.out_rd}, 32'd0);
    check_val("rst_stall", {16'd0, stall_cnt}, 32'd0);
    rst_n = 1'b1;
    #1 check_val("rel_ready", {31'd0, sif.in_ready}, 32'd1);

    // SLLI x5 by 4
    @(negedge clk);
    applyStimulus(5'd5, 32'h0000_00F0, 5'd0, 32'd0, 5'd3, 32'd4, 3'b001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("slli");

    // SRA with rs2 produced by both forwarding stages
    exm_v = 1'b1; exm_rd = 5'd7; exm_d = 32'h0000_001F;
    mwb_v = 1'b1; mwb_rd = 5'd7; mwb_d = 32'h0000_0003;
    applyStimulus(5'd2, 32'h8000_0000, 5'd7, 32'd0, 5'd4, 32'd0, 3'b101, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("sra_fwd");

    // SRL with rs2 only in MEM/WB, rs1 from EX/MEM
    exm_v = 1'b1; exm_rd = 5'd9; exm_d = 32'h1234_5678;
    mwb_v = 1'b1; mwb_rd = 5'd7; mwb_d = 32'h0000_0003;
    applyStimulus(5'd9, 32'hAAAA_AAAA, 5'd7, 32'h0000_0011, 5'd10, 32'd0, 3'b101, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("srl_mwb");

    // Non-shift funct3 passes through; shamt from rs2 register value
    exm_v = 1'b0; mwb_v = 1'b0;
    applyStimulus(5'd12, 32'hCAFE_F00D, 5'd13, 32'hFFFF_FFE6, 5'd31, 32'd0, 3'b000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("pass");

    // x0 must not pick up a forwarded value
    exm_v = 1'b1; exm_rd = 5'd0; exm_d = 32'hDEAD_BEEF;
    applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd2, 3'b001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("x0_guard");
    check_val("x0_a_zero", sif.out_a, 32'd0);
    exm_v = 1'b0; exm_rd = '0; exm_d = '0;

    // Back-pressure for three cycles
    applyStimulus(5'd4, 32'h0F0F_0F0F, 5'd0, 32'd0, 5'd6, 32'd17, 3'b101, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp_first");
    sif.out_ready = 1'b0;
    applyStimulus(5'd8, 32'h5555_0000, 5'd0, 32'd0, 5'd11, 32'd9, 3'b001, 1'b0, 1'b1, 1'b0);
    #1 check_val("bp_ready0", {31'd0, sif.in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_held("bp_hold");
    end
    check_val("bp_stall3", {16'd0, stall_cnt}, 32'd3);
    sif.out_ready = 1'b1;
    applyStimulus(5'd8, 32'h5555_0000, 5'd0, 32'd0, 5'd11, 32'd9, 3'b001, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bp_next");

    // Flush colliding with a new input
    flush = 1'b1;
    applyStimulus(5'd3, 32'h7777_7777, 5'd0, 32'd0, 5'd2, 32'd1, 3'b001, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    idle_input();
    check_val("flush_valid", {31'd0, sif.out_valid}, 32'd0);
    check_val("flush_stall", {16'd0, stall_cnt}, 32'd3);
    @(negedge clk);
    check_val("flush_dropped", {31'd0, sif.out_valid}, 32'd0);

    // Long stall saturates the counter, then reset mid-stall
    applyStimulus(5'd14, 32'h0BAD_F00D, 5'd0, 32'd0, 5'd15, 32'd5, 3'b101, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("sat_op");
    sif.out_ready = 1'b0;
    repeat (70000) @(negedge clk);
    check_val("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
    check_val("sat_valid", {31'd0, sif.out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_valid", {31'd0, sif.out_valid}, 32'd0);
    check_val("rst_mid_stall", {16'd0, stall_cnt}, 32'd0);
    check_val("rst_mid_type", {30'd0, sif.out_type}, 32'd3);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("rel2_ready", {31'd0, sif.in_ready}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("rel2_no_out", {31'd0, sif.out_valid}, 32'd0);
    end
    sif.out_ready = 1'b1;

    // Normal operation after reset
    applyStimulus(5'd21, 32'h0000_0001, 5'd22, 32'h0000_0008, 5'd23, 32'd0, 3'b001, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    idle_input();
    checkOutput("post_rst");
    check_val("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_operand_stage.md
SHIFT_OPERAND_STAGE -- requirements
Module: shift_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid, in_ready  in/out  1 each  decoded-instruction handshake from decode.
REQ-005 Port: in_rs1_val, in_rs2_val  in  XLEN each  register-file read data.
REQ-006 Port: in_rs1_idx, in_rs2_idx, in_rd_idx  in  5 each  register indices.
REQ-007 Port: in_imm  in  XLEN  immediate; only bits [4:0] are used.
REQ-008 Port: in_funct3 (3), in_funct7b5 (1), in_use_imm (1)  in  decode fields.
REQ-009 Port: flush  in  1  branch/exception kill.
REQ-010 Port: exm_fwd_valid (1), exm_fwd_rd (5), exm_fwd_data (XLEN)  in  EX/MEM forward source.
REQ-011 Port: mwb_fwd_valid (1), mwb_fwd_rd (5), mwb_fwd_data (XLEN)  in  MEM/WB forward source.
REQ-012 Port: out_valid (out, 1), out_ready (in, 1)  handshake to the shifter stage.
REQ-013 Port: out_a (XLEN), out_shamt (5), out_type (2), out_rd (5)  out  registered shifter operands.
REQ-014 Port: stall_cnt  out  16  saturating count of back-pressure cycles.

Function
REQ-015 The block SHALL register one operand set: in_ready = !out_valid || out_ready; it accepts on in_valid && in_ready; latency is 1 cycle.
REQ-016 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-017 The block SHALL select operand sources with priority EX/MEM over MEM/WB over register file, on a match of valid && rd == idx && rd != 0.
REQ-018 Index x0 SHALL never be forwarded; the operand for x0 SHALL always be 0.
REQ-019 out_a SHALL be the resolved rs1 value.
REQ-020 out_shamt SHALL be in_imm[4:0] when in_use_imm=1, else resolved rs2[4:0].
REQ-021 out_type SHALL be decoded from the instruction fields:
- funct3=001 -> 01 (SLL)
- funct3=101 and funct7b5=0 -> 00 (SRL)
- funct3=101 and funct7b5=1 -> 10 (SRA)
- any other funct3 -> 11 (pass)
REQ-022 On flush, out_valid SHALL be 0 next cycle, and an in_valid presented in the same cycle SHALL be dropped.
REQ-023 flush SHALL take priority over acceptance and over holding.
REQ-024 stall_cnt SHALL increment each cycle with out_valid && !out_ready, saturate at 0xFFFF, and never wrap.

Reset
REQ-025 While rst_n=0, the block SHALL hold out_valid=0, out_a=0, out_shamt=0, out_type=11, out_rd=0, and stall_cnt=0.
REQ-026 Reset asserted mid-stall SHALL discard the held operand set, with no output on release.
REQ-027 In the first cycle after rst_n rises, in_ready SHALL be 1.

Configuration
REQ-028 Macro SHIFT_OPERAND_FWD_EN SHALL control operand forwarding.
REQ-029 With SHIFT_OPERAND_FWD_EN defined, forwarding SHALL follow REQ-017.
REQ-030 Without SHIFT_OPERAND_FWD_EN, operands SHALL come only from in_rs1_val/in_rs2_val, and the fwd ports SHALL remain present but ignored.

Structure
REQ-031 Package shift_pkg SHALL hold the shift-type encodings (SRL=00, SLL=01, SRA=10, PASS=11), funct3 constants 001/101, and XLEN.
REQ-032 Sub-module shift_fwd_mux (priority forwarding select for one operand) SHALL be instantiated twice, once for rs1 and once for rs2.

Verification
REQ-033 Accept SLLI: rs1=x5=0x0000_00F0, imm=4, funct3=001, use_imm=1 -> next cycle out_a=0x0000_00F0, out_shamt=4, out_type=01.
REQ-034 SRA rs2 forwarding: rs2=x7, rs2 val=0, funct3=101, f7b5=1, use_imm=0, exm_fwd_valid=1, exm rd=7, exm data=0x1F, mwb rd=7, mwb data=0x03 -> out_shamt=0x1F, out_type=10 (EX/MEM wins).
REQ-035 x0 guard: rs1_idx=0, exm_fwd_valid=1, exm_fwd_rd=0, exm data=0xDEAD_BEEF -> out_a=0.
REQ-036 Back-pressure: out_ready=0 for 3 cycles after a valid output -> outputs stable, in_ready=0, stall_cnt=3; then out_ready=1 -> next operand accepted.
REQ-037 Flush collision: flush=1 with in_valid=1 -> out_valid=0 next cycle and stall_cnt unchanged.
REQ-038 Saturation and reset: hold back-pressure for 70000 cycles -> stall_cnt=0xFFFF; then rst_n=0 mid-stall -> out_valid=0 and stall_cnt=0 immediately.
